// File: rtl/io_cycle_master_pkg.sv
// -----------------------------------------------------------------------------
// io_cycle_master_pkg
// Shared types for the Z80-style I/O cycle initiator.
//   io_state_t : T-state sequencer states (IDLE .. DONE)
//   io_req_t   : a latched host request (direction, port address, write data)
//   io_read_result() : data returned to the host at the end of a cycle
// -----------------------------------------------------------------------------
package io_cycle_master_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_T1 = 3'd1,
    T1      = 3'd2,
    T2      = 3'd3,
    TW      = 3'd4,
    T3      = 3'd5,
    DONE    = 3'd6
  } io_state_t;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } io_req_t;

  // OUT cycles report zero; IN cycles report the responder byte, or the
  // floating-bus value when nobody drives d_in.
  function automatic logic [7:0] io_read_result(
    input logic       write,
    input logic       active,
    input logic [7:0] d,
    input logic [7:0] float_value
  );
    logic [7:0] result;
    if (write) begin
      result = 8'h00;
    end else if (active) begin
      result = d;
    end else begin
      result = float_value;
    end
    return result;
  endfunction

endpackage

// File: rtl/io_cycle_master.sv
// -----------------------------------------------------------------------------
// io_cycle_master
// Initiator end of the CPU I/O port protocol. One host request at a time is
// turned into a T-state timed IN/OUT cycle on the shared I/O bus; the result
// (IN data, or 8'h00 for OUT) is returned through a valid/ready response.
//
// Ports
//   clk28, rst        : 28 MHz clock, asynchronous active-high reset
//   clkcpu_ck         : one-clk28 strobe at each CPU T-state boundary
//   req_*             : host request handshake (write, addr, wdata)
//   rsp_*             : host response handshake (rdata)
//   bus_a/bus_d       : address / write data to port responders
//   bus_ioreq/rd/wr   : registered I/O strobes
//   d_in, d_in_active : responder read data and its drive indication
//   busy              : a cycle is in progress
// -----------------------------------------------------------------------------
module io_cycle_master
  import io_cycle_master_pkg::*;
#(
  parameter int         WAIT_STATES = 1,
  parameter logic [7:0] FLOAT_VALUE = 8'hFF
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        clkcpu_ck,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_d,
  output logic        bus_ioreq,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic [7:0]  d_in,
  input  logic        d_in_active,
  output logic        busy
);

  generate
    if (WAIT_STATES < 0 || WAIT_STATES > 3) begin : g_bad_wait_states
      $error("io_cycle_master: WAIT_STATES must be in 0..3");
    end
  endgenerate

  // Count value on which the last TW state ends.
  localparam logic [1:0] TW_LAST = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;
  localparam bit         HAS_TW  = (WAIT_STATES > 0);

  io_state_t   r_state, w_state_next;
  io_req_t     r_req, w_req_next;
  logic [1:0]  r_wcnt, w_wcnt_next;
  logic [15:0] r_bus_a, w_bus_a_next;
  logic [7:0]  r_bus_d, w_bus_d_next;
  logic        r_ioreq, w_ioreq_next;
  logic        r_rd, w_rd_next;
  logic        r_wr, w_wr_next;
  logic        r_rsp_valid, w_rsp_valid_next;
  logic [7:0]  r_rsp_rdata, w_rsp_rdata_next;
  logic        w_req_ready;
  logic        w_handshake;

  // A pending response blocks acceptance, so at most one request is in flight.
  assign w_req_ready = (r_state == IDLE) && !r_rsp_valid;
  assign w_handshake = req_valid && w_req_ready;

  // Next-state and next-output logic; the bus outputs are computed here and
  // registered below so the strobes are glitch-free.
  always_comb begin
    w_state_next     = r_state;
    w_req_next       = r_req;
    w_wcnt_next      = r_wcnt;
    w_bus_a_next     = r_bus_a;
    w_bus_d_next     = r_bus_d;
    w_ioreq_next     = r_ioreq;
    w_rd_next        = r_rd;
    w_wr_next        = r_wr;
    w_rsp_rdata_next = r_rsp_rdata;
    // The host drains the response; T3 below can only set it while clear.
    w_rsp_valid_next = (r_rsp_valid && rsp_ready) ? 1'b0 : r_rsp_valid;

    case (r_state)
      IDLE: begin
        if (w_handshake) begin
          w_state_next     = WAIT_T1;
          w_req_next.write = req_write;
          w_req_next.addr  = req_addr;
          w_req_next.wdata = req_wdata;
        end else begin
          w_state_next = IDLE;
        end
      end
      // A boundary strobe coincident with acceptance is not seen here, since
      // this state is only entered after that edge.
      WAIT_T1: begin
        if (clkcpu_ck) begin
          w_state_next = T1;
          w_bus_a_next = r_req.addr;
        end else begin
          w_state_next = WAIT_T1;
        end
      end
      T1: begin
        if (clkcpu_ck) begin
          w_state_next = T2;
          w_ioreq_next = 1'b1;
          w_rd_next    = !r_req.write;
          w_wr_next    = r_req.write;
          w_bus_d_next = r_req.write ? r_req.wdata : 8'h00;
        end else begin
          w_state_next = T1;
        end
      end
      T2: begin
        if (clkcpu_ck) begin
          w_wcnt_next = 2'd0;
          if (HAS_TW) begin
            w_state_next = TW;
          end else begin
            w_state_next = T3;
          end
        end else begin
          w_state_next = T2;
        end
      end
      TW: begin
        if (clkcpu_ck) begin
          if (r_wcnt == TW_LAST) begin
            w_state_next = T3;
          end else begin
            w_state_next = TW;
            w_wcnt_next  = r_wcnt + 2'd1;
          end
        end else begin
          w_state_next = TW;
        end
      end
      T3: begin
        if (clkcpu_ck) begin
          w_state_next     = DONE;
          w_ioreq_next     = 1'b0;
          w_rd_next        = 1'b0;
          w_wr_next        = 1'b0;
          w_bus_a_next     = 16'h0000;
          w_bus_d_next     = 8'h00;
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = io_read_result(r_req.write, d_in_active, d_in, FLOAT_VALUE);
        end else begin
          w_state_next = T3;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
        w_ioreq_next = 1'b0;
        w_rd_next    = 1'b0;
        w_wr_next    = 1'b0;
        w_bus_a_next = 16'h0000;
        w_bus_d_next = 8'h00;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request latch, wait counter and registered bus/response outputs; reset
  // discards any in-flight request and drops the strobes at once.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_req       <= '0;
      r_wcnt      <= 2'd0;
      r_bus_a     <= 16'h0000;
      r_bus_d     <= 8'h00;
      r_ioreq     <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
    end else begin
      r_req       <= w_req_next;
      r_wcnt      <= w_wcnt_next;
      r_bus_a     <= w_bus_a_next;
      r_bus_d     <= w_bus_d_next;
      r_ioreq     <= w_ioreq_next;
      r_rd        <= w_rd_next;
      r_wr        <= w_wr_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_rdata <= w_rsp_rdata_next;
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign bus_a     = r_bus_a;
  assign bus_d     = r_bus_d;
  assign bus_ioreq = r_ioreq;
  assign bus_rd    = r_rd;
  assign bus_wr    = r_wr;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_io_cycle_master.sv
// -----------------------------------------------------------------------------
// tb_io_cycle_master
// Three instances (WAIT_STATES = 0, 1, 3) share one host stimulus stream. Each
// transaction is timed against T-state arithmetic: bus_a appears at the first
// boundary strictly after acceptance, strobes follow one T-state later and last
// (2 + WAIT_STATES) T-states, the response rises (3 + WAIT_STATES) T-states
// after bus_a.
// -----------------------------------------------------------------------------
module tb_io_cycle_master;

  localparam int NDUT = 3;
  localparam int CKP  = 8;

  function automatic int ws_of(input int i);
    case (i)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  logic        clk28 = 1'b0;
  logic        rst = 1'b1;
  logic        clkcpu_ck;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        rsp_ready = 1'b0;
  logic [7:0]  d_in = 8'h00;
  logic        d_in_active = 1'b0;

  logic        req_ready [NDUT];
  logic        rsp_valid [NDUT];
  logic [7:0]  rsp_rdata [NDUT];
  logic [15:0] bus_a [NDUT];
  logic [7:0]  bus_d [NDUT];
  logic        bus_ioreq [NDUT];
  logic        bus_rd [NDUT];
  logic        bus_wr [NDUT];
  logic        busy [NDUT];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk28 = ~clk28;

  // Edge counter; the DUT sees clkcpu_ck on edge n when n % CKP == CKP-1.
  always @(posedge clk28) cyc <= cyc + 1;
  assign clkcpu_ck = ((cyc % CKP) == (CKP - 1));

  generate
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
      io_cycle_master #(.WAIT_STATES(ws_of(g)), .FLOAT_VALUE(8'hFF)) u_dut (
        .clk28(clk28), .rst(rst), .clkcpu_ck(clkcpu_ck),
        .req_valid(req_valid), .req_ready(req_ready[g]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[g]),
        .bus_a(bus_a[g]), .bus_d(bus_d[g]), .bus_ioreq(bus_ioreq[g]),
        .bus_rd(bus_rd[g]), .bus_wr(bus_wr[g]),
        .d_in(d_in), .d_in_active(d_in_active), .busy(busy[g])
      );
    end
  endgenerate

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic string tg(input string n, input int i, input int id);
    return $sformatf("%s/ws%0d/t%0d", n, ws_of(i), id);
  endfunction

  // One full request/response exchange, started and ended at a negedge.
  task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                        input logic [7:0] din, input logic act, input int gap,
                        input int hold, input bit align, input int id);
    int a, e, e0;
    int a_first [NDUT];
    int a_cnt [NDUT];
    int io_first [NDUT];
    int io_cnt [NDUT];
    int rsp_first [NDUT];
    int bad [NDUT];
    logic [7:0] exp_d;
    bit all_rsp;

    repeat (gap) @(negedge clk28);
    req_write = wr; req_addr = addr; req_wdata = wdata;
    d_in = din; d_in_active = act;
    if (align) begin
      for (int k = 0; k < CKP && ((cyc % CKP) != (CKP - 1)); k++) @(negedge clk28);
    end
    for (int i = 0; i < NDUT; i++) check_eq(tg("ready_idle", i, id), req_ready[i], 1);
    req_valid = 1'b1;
    a = cyc;
    @(negedge clk28);
    req_valid = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      check_eq(tg("busy", i, id), busy[i], 1);
      a_first[i] = -1; a_cnt[i] = 0; io_first[i] = -1; io_cnt[i] = 0;
      rsp_first[i] = -1; bad[i] = 0;
    end
    exp_d = wr ? 8'h00 : (act ? din : 8'hFF);
    e0 = a + 1;
    while ((e0 % CKP) != (CKP - 1)) e0++;

    all_rsp = 1'b0;
    for (int k = 0; k < 600 && !all_rsp; k++) begin
      @(negedge clk28);
      e = cyc - 1;
      all_rsp = 1'b1;
      for (int i = 0; i < NDUT; i++) begin
        if (bus_a[i] == addr) begin
          if (a_first[i] < 0) a_first[i] = e;
          a_cnt[i]++;
        end else if (bus_a[i] != 16'h0000) begin
          bad[i]++;
        end
        if (bus_ioreq[i]) begin
          if (io_first[i] < 0) io_first[i] = e;
          io_cnt[i]++;
          if ((bus_rd[i] !== ~wr) || (bus_wr[i] !== wr)) bad[i]++;
          if (wr && (bus_d[i] != wdata)) bad[i]++;
        end else if (bus_rd[i] || bus_wr[i]) begin
          bad[i]++;
        end
        if (rsp_valid[i]) begin
          if (rsp_first[i] < 0) rsp_first[i] = e;
          if ((rsp_rdata[i] != exp_d) || req_ready[i]) bad[i]++;
        end else begin
          all_rsp = 1'b0;
        end
      end
    end
    if (!all_rsp) check_eq($sformatf("timeout/t%0d", id), 0, 1);

    // Host stalls the response while offering a new request.
    req_valid = 1'b1;
    repeat (hold) begin
      @(negedge clk28);
      for (int i = 0; i < NDUT; i++)
        if (!rsp_valid[i] || (rsp_rdata[i] != exp_d) || req_ready[i] || busy[i]) bad[i]++;
    end
    rsp_ready = 1'b1;
    @(negedge clk28);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      check_eq(tg("consumed", i, id), rsp_valid[i], 0);
      check_eq(tg("ready_after", i, id), req_ready[i], 1);
      check_eq(tg("not_accepted", i, id), busy[i], 0);
      check_eq(tg("addr_edge", i, id), a_first[i], e0);
      check_eq(tg("addr_len", i, id), a_cnt[i], (3 + ws_of(i)) * CKP);
      check_eq(tg("strobe_edge", i, id), io_first[i], e0 + CKP);
      check_eq(tg("strobe_len", i, id), io_cnt[i], (2 + ws_of(i)) * CKP);
      check_eq(tg("rsp_edge", i, id), rsp_first[i], e0 + (3 + ws_of(i)) * CKP);
      check_eq(tg("rdata", i, id), rsp_rdata[i], exp_d);
      check_eq(tg("protocol", i, id), bad[i], 0);
    end
  endtask

  // Reset asserted while the WAIT_STATES=1 instance sits in TW of an OUT cycle.
  task automatic reset_mid();
    int stale;
    req_write = 1'b1; req_addr = 16'hABCD; req_wdata = 8'h3C; req_valid = 1'b1;
    @(negedge clk28);
    req_valid = 1'b0;
    for (int k = 0; k < 100 && !bus_ioreq[1]; k++) @(negedge clk28);
    check_eq("rst_reach_t2", bus_ioreq[1], 1);
    repeat (CKP + 2) @(negedge clk28);
    check_eq("pre_rst_wr", bus_wr[1], 1);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check_eq(tg("rst_async_strobes", i, 0), {bus_ioreq[i], bus_rd[i], bus_wr[i]}, 0);
      check_eq(tg("rst_async_busy", i, 0), busy[i], 0);
    end
    @(negedge clk28);
    @(negedge clk28);
    rst = 1'b0;
    @(negedge clk28);
    stale = 0;
    for (int i = 0; i < NDUT; i++) begin
      check_eq(tg("post_rst_ready", i, 0), req_ready[i], 1);
      check_eq(tg("post_rst_rsp", i, 0), rsp_valid[i], 0);
    end
    repeat (50) begin
      @(negedge clk28);
      for (int i = 0; i < NDUT; i++) if (rsp_valid[i] || bus_ioreq[i] || busy[i]) stale++;
    end
    check_eq("no_stale", stale, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic        w;
    logic [15:0] ad;
    logic [7:0]  wd, di;
    logic        ac;
    repeat (3) @(negedge clk28);
    for (int i = 0; i < NDUT; i++) begin
      check_eq(tg("rst_bus_a", i, 0), bus_a[i], 0);
      check_eq(tg("rst_bus_d", i, 0), bus_d[i], 0);
      check_eq(tg("rst_strobes", i, 0), {bus_ioreq[i], bus_rd[i], bus_wr[i]}, 0);
      check_eq(tg("rst_rsp", i, 0), {rsp_valid[i], rsp_rdata[i]}, 0);
      check_eq(tg("rst_busy", i, 0), busy[i], 0);
      check_eq(tg("rst_ready", i, 0), req_ready[i], 1);
    end
    rst = 1'b0;
    @(negedge clk28);

    do_txn(1'b1, 16'h00FE, 8'h15, 8'h00, 1'b0, 2, 0, 1'b1, 1);
    do_txn(1'b0, 16'h001F, 8'h00, 8'h0A, 1'b1, 3, 10, 1'b0, 2);
    do_txn(1'b0, 16'h7FFE, 8'h00, 8'h5A, 1'b0, 5, 3, 1'b1, 3);
    for (int t = 0; t < 24; t++) begin
      w  = 1'($urandom_range(0, 1));
      ad = 16'($urandom_range(1, 65535));
      wd = 8'($urandom_range(0, 255));
      di = 8'($urandom_range(0, 255));
      ac = 1'($urandom_range(0, 1));
      do_txn(w, ad, wd, di, ac, $urandom_range(0, 12), $urandom_range(0, 10),
             ($urandom_range(0, 3) == 0), 10 + t);
    end
    reset_mid();
    do_txn(1'b0, 16'h1234, 8'h00, 8'hC3, 1'b1, 1, 2, 1'b0, 99);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
